// File: rtl/flappy_pkg.sv
// Shared constants for the flappy game: scene codes, screen geometry and
// the bird physics FSM state encoding.
package flappy_pkg;

    typedef enum logic [1:0] {
        SCENE_START = 2'b00,
        SCENE_PLAY  = 2'b01,
        SCENE_OVER  = 2'b10
    } scene_t;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int GROUND_ROW = 440;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FLY   = 2'b01,
        DYING = 2'b10,
        DEAD  = 2'b11
    } bird_state_t;

endpackage

// File: rtl/bird_physics_if.sv
// Bundle of the per-frame game inputs and the bird status outputs.
interface bird_physics_if;

    logic        frame_tick;
    logic [1:0]  state_number;
    logic        flap_button;
    logic [9:0]  pipe_x;
    logic [8:0]  gap_top;
    logic [8:0]  gap_bottom;
    logic [9:0]  bird_y;
    logic signed [5:0] bird_vel;
    logic        dead;
    logic        pass_pulse;

    modport master (
        output frame_tick, state_number, flap_button, pipe_x, gap_top, gap_bottom,
        input  bird_y, bird_vel, dead, pass_pulse
    );

    modport slave (
        input  frame_tick, state_number, flap_button, pipe_x, gap_top, gap_bottom,
        output bird_y, bird_vel, dead, pass_pulse
    );

endinterface

// File: rtl/button_edge.sv
// Two-flop synchroniser for an active-low key plus a falling-edge (press)
// detector; shared by the flap, start and restart keys.
module button_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic fall
);

    logic [1:0] sync_q;
    logic       prev_q;

    // The edge is taken from the second flop only, so the first flop is
    // free to resolve metastability before anything looks at it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], btn};
            prev_q <= sync_q[1];
        end
    end

    assign fall = prev_q & ~sync_q[1];

endmodule

// File: rtl/bird_physics.sv
// Per-frame bird motion: gravity/flap integration, ceiling clamp, ground and
// pipe collision, death fall and pipe-pass pulse.
module bird_physics
    import flappy_pkg::*;
#(
    parameter int BIRD_X   = 160,
    parameter int BIRD_W   = 16,
    parameter int BIRD_H   = 16,
    parameter int PIPE_W   = 52,
    parameter int GROUND_Y = GROUND_ROW,
    parameter int START_Y  = 220,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = -8,
    parameter int MAX_FALL = 10
) (
    input logic           clk,
    input logic           rst,
    bird_physics_if.slave bus
);

    localparam logic signed [11:0] GRAV12   = 12'(GRAVITY);
    localparam logic signed [11:0] FLAP12   = 12'(FLAP_VEL);
    localparam logic signed [11:0] MAXF12   = 12'(MAX_FALL);
    localparam logic signed [11:0] BH12     = 12'(BIRD_H);
    localparam logic signed [11:0] GROUND12 = 12'(GROUND_Y);
    localparam logic [9:0]  START_Y10 = 10'(START_Y);
    localparam logic [9:0]  LAND_Y10  = 10'(GROUND_Y - BIRD_H);
    localparam logic [10:0] BIRD_L11  = 11'(BIRD_X);
    localparam logic [10:0] BIRD_R11  = 11'(BIRD_X + BIRD_W);
    localparam logic [10:0] PIPE_W11  = 11'(PIPE_W);

    bird_state_t       state_q, state_d;
    logic [9:0]        y_q, y_d;
    logic signed [5:0] vel_q, vel_d;
    logic              pending_q, pending_d;
    logic              passed_q, passed_d;
    logic              pass_q, pass_d;
    logic              flap_fall;

    logic signed [11:0] y_ext, vel_ext, vel_inc, grav_vel, fly_vel, fly_y, dive_y;
    logic [10:0]        pipe_r;
    logic               h_overlap, v_outside, pipe_hit, fly_ground, dive_ground, now_passed;
    logic               scene_start, scene_play, scene_over;

    button_edge u_flap_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (bus.flap_button),
        .fall (flap_fall)
    );

    assign scene_start = (bus.state_number == SCENE_START);
    assign scene_play  = (bus.state_number == SCENE_PLAY);
    assign scene_over  = (bus.state_number == SCENE_OVER);

    // Candidate motion for this tick, all in 12-bit signed so a flap near the
    // top can go negative before being clamped.
    assign y_ext    = $signed({2'b00, y_q});
    assign vel_ext  = {{6{vel_q[5]}}, vel_q};
    assign vel_inc  = vel_ext + GRAV12;
    assign grav_vel = (vel_inc > MAXF12) ? MAXF12 : vel_inc;
    assign fly_vel  = pending_q ? FLAP12 : grav_vel;
    assign fly_y    = y_ext + fly_vel;
    assign dive_y   = y_ext + grav_vel;

    assign fly_ground  = (fly_y + BH12) >= GROUND12;
    assign dive_ground = (dive_y + BH12) >= GROUND12;

    assign pipe_r     = {1'b0, bus.pipe_x} + PIPE_W11;
    assign h_overlap  = ({1'b0, bus.pipe_x} < BIRD_R11) && (pipe_r > BIRD_L11);
    assign v_outside  = (fly_y < $signed({3'b000, bus.gap_top})) ||
                        ((fly_y + BH12) > $signed({3'b000, bus.gap_bottom}));
    assign pipe_hit   = h_overlap && v_outside;
    assign now_passed = pipe_r < BIRD_L11;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            y_q       <= START_Y10;
            vel_q     <= '0;
            pending_q <= 1'b0;
            passed_q  <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            vel_q     <= vel_d;
            pending_q <= pending_d;
            passed_q  <= passed_d;
            pass_q    <= pass_d;
        end
    end

    // A pipe hit discards any flap: the bird keeps the collided position but
    // takes the gravity velocity, so it starts falling immediately.
    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        vel_d     = vel_q;
        pending_d = pending_q;
        passed_d  = passed_q;
        pass_d    = 1'b0;

        if (bus.frame_tick) begin
            pending_d = flap_fall;
            passed_d  = now_passed;
        end else if (flap_fall) begin
            pending_d = 1'b1;
        end

        if (scene_start) begin
            state_d   = IDLE;
            y_d       = START_Y10;
            vel_d     = '0;
            pending_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (scene_play) state_d = FLY;
                end
                FLY: begin
                    if (bus.frame_tick && scene_play) begin
                        pass_d = now_passed && !passed_q;
                        if (fly_ground) begin
                            state_d = DEAD;
                            y_d     = LAND_Y10;
                            vel_d   = '0;
                        end else if (pipe_hit) begin
                            state_d = DYING;
                            y_d     = (fly_y < 0) ? 10'd0 : fly_y[9:0];
                            vel_d   = grav_vel[5:0];
                        end else if (fly_y < 0) begin
                            y_d     = 10'd0;
                            vel_d   = '0;
                        end else begin
                            y_d     = fly_y[9:0];
                            vel_d   = fly_vel[5:0];
                        end
                    end
                end
                DYING: begin
                    if (bus.frame_tick && (scene_play || scene_over)) begin
                        if (dive_ground) begin
                            state_d = DEAD;
                            y_d     = LAND_Y10;
                            vel_d   = '0;
                        end else begin
                            y_d     = (dive_y < 0) ? 10'd0 : dive_y[9:0];
                            vel_d   = grav_vel[5:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bird_y     = y_q;
    assign bus.bird_vel   = vel_q;
    assign bus.dead       = (state_q == DYING) || (state_q == DEAD);
    assign bus.pass_pulse = pass_q;

endmodule

// File: tb/tb_bird_physics.sv
// Randomised frame-by-frame bench for bird_physics against a plain-arithmetic
// model of the bird's motion rules, plus a few directed scenarios.
module tb_bird_physics;

    localparam int BX = 160, BW = 16, BH = 16, PW = 52, GROUND = 440, START = 220;

    logic clk = 1'b0;
    logic rst = 1'b0;

    bird_physics_if bus ();

    bird_physics dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int mY, mVel;
    bit mFlying, mDying, mLanded, mPending, mWasPassed, mPass;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic tick, input logic btn);
        bus.frame_tick  = tick;
        bus.flap_button = btn;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".y"},    int'(bus.bird_y), mY);
        checkOutput({tag, ".vel"},  int'($signed(bus.bird_vel)), mVel);
        checkOutput({tag, ".dead"}, int'(bus.dead), int'(mDying || mLanded));
        checkOutput({tag, ".pass"}, int'(bus.pass_pulse), int'(mPass));
    endtask

    task automatic modelReset();
        mY = START; mVel = 0;
        mFlying = 0; mDying = 0; mLanded = 0;
        mPending = 0; mWasPassed = 0; mPass = 0;
    endtask

    // One frame: scene and pipe held for the frame, optional presses early on,
    // quiet cycles so every press has settled, then a single tick cycle.
    task automatic doFrame(input logic [1:0] sn, input int presses, input int px,
                           input int gt, input int gb);
        int grav, nv, ny;
        bit passedNow, horiz;
        bus.state_number = sn;
        bus.pipe_x       = 10'(px);
        bus.gap_top      = 9'(gt);
        bus.gap_bottom   = 9'(gb);
        mPass = 0;
        if (sn == 2'b00) begin
            mY = START; mVel = 0;
            mFlying = 0; mDying = 0; mLanded = 0; mPending = 0;
        end else begin
            if (!mFlying && !mDying && !mLanded && sn == 2'b01) mFlying = 1;
            if (presses > 0) mPending = 1;
        end
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, !((c == 0 && presses >= 1) || (c == 2 && presses >= 2)));
            if (c == 5) checkAll("midFrame");
        end

        passedNow = (px + PW) < BX;
        horiz     = (px < BX + BW) && (px + PW > BX);
        grav      = (mVel + 1 > 10) ? 10 : mVel + 1;
        if (mFlying && sn == 2'b01) begin
            nv    = mPending ? -8 : grav;
            ny    = mY + nv;
            mPass = passedNow && !mWasPassed;
            if (ny + BH >= GROUND) begin
                mY = GROUND - BH; mVel = 0; mFlying = 0; mLanded = 1;
            end else if (horiz && (ny < gt || ny + BH > gb)) begin
                mFlying = 0; mDying = 1; mY = (ny < 0) ? 0 : ny; mVel = grav;
            end else if (ny < 0) begin
                mY = 0; mVel = 0;
            end else begin
                mY = ny; mVel = nv;
            end
        end else if (mDying && sn != 2'b00) begin
            ny = mY + grav;
            if (ny + BH >= GROUND) begin
                mY = GROUND - BH; mVel = 0; mDying = 0; mLanded = 1;
            end else begin
                mY = (ny < 0) ? 0 : ny; mVel = grav;
            end
        end
        mPending   = 0;
        mWasPassed = passedNow;
        applyStimulus(1'b1, 1'b1);
        checkAll("tick");
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int expY[3];
        int expV[3];
        int sn, presses, gt, r;
        expY[0] = 221; expY[1] = 223; expY[2] = 226;
        expV[0] = 1;   expV[1] = 2;   expV[2] = 3;

        bus.frame_tick   = 1'b0;
        bus.flap_button  = 1'b1;
        bus.state_number = 2'b00;
        bus.pipe_x       = 10'd400;
        bus.gap_top      = 9'd0;
        bus.gap_bottom   = 9'd480;

        rst = 1'b0;
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        modelReset();
        checkAll("reset");
        rst = 1'b1;

        for (int i = 0; i < 3; i++) begin
            doFrame(2'b01, 0, 400, 0, 480);
            checkOutput("fallY",   int'(bus.bird_y), expY[i]);
            checkOutput("fallVel", int'($signed(bus.bird_vel)), expV[i]);
        end

        doFrame(2'b01, 2, 400, 0, 480);
        checkOutput("doubleFlapVel", int'($signed(bus.bird_vel)), -8);
        checkOutput("doubleFlapY",   int'(bus.bird_y), 218);

        for (int i = 0; i < 40 && mY != 0; i++) doFrame(2'b01, 1, 400, 0, 480);
        checkOutput("ceilingY",    int'(bus.bird_y), 0);
        checkOutput("ceilingVel",  int'($signed(bus.bird_vel)), 0);
        checkOutput("ceilingDead", int'(bus.dead), 0);

        doFrame(2'b00, 0, 150, 100, 200);
        doFrame(2'b01, 0, 150, 100, 200);
        checkOutput("pipeHitDead", int'(bus.dead), 1);
        for (int i = 0; i < 60 && !mLanded; i++) doFrame(2'b01, 1, 150, 100, 200);
        checkOutput("landedY",    int'(bus.bird_y), 424);
        checkOutput("landedVel",  int'($signed(bus.bird_vel)), 0);
        checkOutput("landedDead", int'(bus.dead), 1);
        doFrame(2'b00, 0, 150, 100, 200);
        checkOutput("reinitY",    int'(bus.bird_y), 220);
        checkOutput("reinitDead", int'(bus.dead), 0);

        doFrame(2'b01, 0, 150, 100, 200);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1);
        rst = 1'b1;
        modelReset();
        checkAll("midDyingReset");

        doFrame(2'b00, 0, 109, 0, 480);
        doFrame(2'b01, 0, 109, 0, 480);
        checkOutput("noPassYet", int'(bus.pass_pulse), 0);
        doFrame(2'b01, 0, 107, 0, 480);
        checkOutput("passPulse", int'(bus.pass_pulse), 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("passOneClk", int'(bus.pass_pulse), 0);

        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(0, 99));
            if ((mLanded && r < 40) || r < 4) sn = 0;
            else if (r < 14) sn = 2;
            else sn = 1;
            presses = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 2)) : 0;
            gt = int'($urandom_range(40, 300));
            doFrame(2'(sn), presses, int'($urandom_range(0, 639)), gt,
                    gt + int'($urandom_range(60, 160)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bird_physics.md
BIRD_PHYSICS -- requirements
Module: bird_physics

Interface
REQ-001 Parameter BIRD_X, 160: fixed bird left edge, pixels.
REQ-002 Parameter BIRD_W / BIRD_H, 16 / 16: bird box size, pixels.
REQ-003 Parameter PIPE_W, 52: pipe width, pixels.
REQ-004 Parameter GROUND_Y, 440: first ground row.
REQ-005 Parameter START_Y, 220: bird top row after reset or re-init.
REQ-006 Parameter GRAVITY, 1: velocity increment per frame.
REQ-007 Parameter FLAP_VEL, -8: velocity loaded on flap, signed.
REQ-008 Parameter MAX_FALL, 10: velocity ceiling, signed.
REQ-009 Clock and reset: one clock; reset is synchronous and active-low.
REQ-010 clk  in  1  system clock.
REQ-011 rst  in  1  synchronous active-low reset.
REQ-012 frame_tick  in  1  one-cycle pulse per video frame.
REQ-013 state_number  in  2  scene code: 00 start, 01 gameplay, 10 gameover.
REQ-014 flap_button  in  1  raw flap key, active-low, asynchronous.
REQ-015 pipe_x  in  10  left edge of the nearest pipe, pixels.
REQ-016 gap_top / gap_bottom  in  9 each  gap rows [gap_top, gap_bottom).
REQ-017 bird_y  out  10  bird top row.
REQ-018 bird_vel  out  6  signed velocity.
REQ-019 dead  out  1  level; feeds the scene controller's dead input.
REQ-020 pass_pulse  out  1  one-cycle pulse when the bird clears a pipe.

Function
REQ-021 The FSM SHALL have four states: IDLE, FLY, DYING and DEAD.
REQ-022 In any state, state_number==00 SHALL force IDLE, bird_y=START_Y, vel=0, dead=0 and clear any pending flap on the next clk.
REQ-023 IDLE SHALL go to FLY on the first clk with state_number==01.
REQ-024 flap_button SHALL pass through a 2-FF synchroniser; a falling edge SHALL set flap_pending.
REQ-025 flap_pending SHALL be cleared on each frame_tick; multiple edges within one frame SHALL give exactly one flap.
REQ-026 On frame_tick in FLY, new_vel SHALL be FLAP_VEL if flap_pending, else min(vel+GRAVITY, MAX_FALL).
REQ-027 On frame_tick in FLY, new_y SHALL be y+new_vel, computed in 12-bit signed.
REQ-028 On frame_tick, if new_y<0, bird_y SHALL be set to 0 and vel to 0; the ceiling is not fatal.
REQ-029 On frame_tick, if new_y+BIRD_H>=GROUND_Y, bird_y SHALL be set to GROUND_Y-BIRD_H and the next state SHALL be DEAD.
REQ-030 On frame_tick, pipe collision SHALL require horizontal overlap: pipe_x < BIRD_X+BIRD_W and pipe_x+PIPE_W > BIRD_X.
REQ-031 Pipe collision SHALL additionally require new_y<gap_top or new_y+BIRD_H>gap_bottom; the next state SHALL then be DYING.
REQ-032 Collision SHALL win over a flap on the same tick; a ground hit SHALL win over a pipe hit.
REQ-033 dead SHALL assert on the clk that enters DYING or DEAD and SHALL hold until the REQ-022 re-init.
REQ-034 DYING SHALL ignore flaps and apply gravity each tick until the ground; on the ground the FSM SHALL enter DEAD with vel=0.
REQ-035 DEAD SHALL hold bird_y and vel.
REQ-036 With state_number==10, all motion SHALL freeze except DYING, which continues to the ground.
REQ-037 pass_pulse SHALL fire once on the frame_tick where pipe_x+PIPE_W first becomes <BIRD_X, in FLY only.
REQ-038 Between frame ticks, bird_y and vel SHALL not change, except through REQ-022.

Reset
REQ-039 When rst==0 at a clk edge: FSM=IDLE, bird_y=START_Y, bird_vel=0, dead=0, pass_pulse=0, flap_pending=0, synchroniser=11.
REQ-040 Reset SHALL override all other inputs, including mid-DYING.

Structure
REQ-041 Package flappy_pkg SHALL hold the scene codes (00/01/10), screen constants and the bird FSM state encoding.
REQ-042 The synchroniser and edge detector SHALL be a sub-module named button_edge, reused for the start and restart keys.

Verification
REQ-043 Reset, then state_number=01 with no flap for 3 ticks -> vel 1,2,3 and bird_y 221,223,226.
REQ-044 Flap in FLY with vel=5 at y=200 -> after the next tick vel=-8, y=192; two presses within one frame -> one flap only.
REQ-045 Bird at y=2, flap -> y clamps to 0, vel=0, dead stays 0.
REQ-046 pipe_x=150, gap 100..200, bird y reaches 190 -> DYING, dead=1 the next clk, bird falls to y=424, then DEAD.
REQ-047 Pipe leaves overlap with pipe_x stepping 109→107 -> pass_pulse high exactly one clk; state_number=00 while in DEAD -> y=220, dead=0 the next clk.
